// File: rtl/shift_unit.sv
// Multi-cycle shifter: one bit per cycle, shifting SLL/SRL/SRA (and ROL/ROR when
// SHIFT_UNIT_ROTATE_EN is defined); done pulses when the shift completes.
module shift_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  state_t              state, state_n;
  logic [DATA_W-1:0]   work, work_n;
  logic [AMT_W-1:0]    cnt, cnt_n;
  logic [2:0]          op_q, op_n;
  logic [DATA_W-1:0]   result_n;
  logic                busy_n, done_n, err_n;

  function automatic logic op_legal(input logic [2:0] o);
    logic ok;
    ok = (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
`ifdef SHIFT_UNIT_ROTATE_EN
    ok = ok || (o == OP_ROL) || (o == OP_ROR);
`endif
    return ok;
  endfunction

  // Single-bit move of the working register for the latched op.
  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] w,
                                             input logic [2:0]        o);
    logic [DATA_W-1:0] r;
    r = w;
    case (o)
      OP_SLL:  r = {w[DATA_W-2:0], 1'b0};
      OP_SRL:  r = {1'b0, w[DATA_W-1:1]};
      OP_SRA:  r = {w[DATA_W-1], w[DATA_W-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROL:  r = {w[DATA_W-2:0], w[DATA_W-1]};
      OP_ROR:  r = {w[0], w[DATA_W-1:1]};
`endif
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_n  = state;
    work_n   = work;
    cnt_n    = cnt;
    op_n     = op_q;
    result_n = result;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          work_n = data_in;
          cnt_n  = shamt;
          op_n   = op;
          if ((shamt == AMT_W'(0)) || !op_legal(op)) begin
            state_n  = DONE;
            result_n = data_in;
            err_n    = !op_legal(op);
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_n = step(work, op_q);
        cnt_n  = cnt - AMT_W'(1);
        // Last shift: publish the result in the same edge that raises done.
        if (cnt == AMT_W'(1)) begin
          state_n  = DONE;
          result_n = step(work, op_q);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      op_q   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

endmodule
